// File: rtl/vga_fill_engine_if.sv
// Interface bundle for the fill engine: command handshake plus Wishbone classic write bus.
// The master modport is the engine's view; the slave modport is the requester/memory side.
interface vga_fill_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        m_cyc;
  logic        m_stb;
  logic        m_we;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_ack;

  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, m_ack,
    output cmd_ready, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel
  );

  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, m_ack,
    input  cmd_ready, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel
  );
endinterface

// File: rtl/vga_fill_engine.sv
// Rectangle fill engine: clips a command to the screen and writes one 32-bit word per
// pixel over Wishbone classic, walking the rectangle row-major without a per-pixel multiply.
module vga_fill_engine #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_fill_engine_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [10:0] col_left, col_left_nxt;
  logic [9:0]  row_left, row_left_nxt;
  logic [10:0] col_reload, col_reload_nxt;
  logic [31:0] row_step, row_step_nxt;

  logic        cmd_ready_nxt, cyc_nxt, stb_nxt, we_nxt;
  logic [31:0] adr_nxt, dat_nxt;
  logic [3:0]  sel_nxt;
  logic        busy_nxt, done_nxt, err_nxt;

  // Clipping arithmetic on the raw command fields (only used on the capture edge)
  logic        x_off, y_off;
  logic [10:0] avail_w, w_clip;
  logic [9:0]  avail_h, h_clip;
  logic [31:0] first_idx, first_adr, step_calc;

  always_comb begin
    x_off     = 11'(bus.cmd_x) >= 11'(WIDTH);
    y_off     = 10'(bus.cmd_y) >= 10'(HEIGHT);
    avail_w   = 11'(WIDTH) - 11'(bus.cmd_x);
    avail_h   = 10'(HEIGHT) - 10'(bus.cmd_y);
    w_clip    = (11'(bus.cmd_w) < avail_w) ? 11'(bus.cmd_w) : avail_w;
    h_clip    = (10'(bus.cmd_h) < avail_h) ? 10'(bus.cmd_h) : avail_h;
    first_idx = 32'(bus.cmd_y) * 32'(WIDTH) + 32'(bus.cmd_x);
    first_adr = BASE_ADDR + (first_idx << 2);
    // Jump from the last pixel of one row to the first pixel of the next
    step_calc = (32'(WIDTH) - 32'(w_clip) + 32'd1) << 2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      col_left      <= '0;
      row_left      <= '0;
      col_reload    <= '0;
      row_step      <= '0;
      bus.cmd_ready <= 1'b1;
      bus.m_cyc     <= 1'b0;
      bus.m_stb     <= 1'b0;
      bus.m_we      <= 1'b0;
      bus.m_adr     <= '0;
      bus.m_dat     <= '0;
      bus.m_sel     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      col_left      <= col_left_nxt;
      row_left      <= row_left_nxt;
      col_reload    <= col_reload_nxt;
      row_step      <= row_step_nxt;
      bus.cmd_ready <= cmd_ready_nxt;
      bus.m_cyc     <= cyc_nxt;
      bus.m_stb     <= stb_nxt;
      bus.m_we      <= we_nxt;
      bus.m_adr     <= adr_nxt;
      bus.m_dat     <= dat_nxt;
      bus.m_sel     <= sel_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    col_left_nxt   = col_left;
    row_left_nxt   = row_left;
    col_reload_nxt = col_reload;
    row_step_nxt   = row_step;
    cyc_nxt        = bus.m_cyc;
    stb_nxt        = bus.m_stb;
    we_nxt         = bus.m_we;
    adr_nxt        = bus.m_adr;
    dat_nxt        = bus.m_dat;
    sel_nxt        = bus.m_sel;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.cmd_valid && bus.cmd_ready) begin
          busy_nxt = 1'b1;
          if (x_off || y_off) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else if (bus.cmd_w == '0 || bus.cmd_h == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt      = WRITE;
            cyc_nxt        = 1'b1;
            stb_nxt        = 1'b1;
            we_nxt         = 1'b1;
            sel_nxt        = 4'hF;
            dat_nxt        = {24'h0, bus.cmd_color};
            adr_nxt        = first_adr;
            row_step_nxt   = step_calc;
            col_reload_nxt = w_clip - 11'd1;
            col_left_nxt   = w_clip - 11'd1;
            row_left_nxt   = h_clip - 10'd1;
          end
        end
      end
      WRITE: begin
        // Advance on the ack edge so the next pixel is presented back-to-back
        if (bus.m_stb && bus.m_ack) begin
          if (col_left != '0) begin
            col_left_nxt = col_left - 11'd1;
            adr_nxt      = bus.m_adr + 32'd4;
          end else if (row_left != '0) begin
            row_left_nxt = row_left - 10'd1;
            col_left_nxt = col_reload;
            adr_nxt      = bus.m_adr + row_step;
          end else begin
            state_nxt = DONE;
            cyc_nxt   = 1'b0;
            stb_nxt   = 1'b0;
            we_nxt    = 1'b0;
            sel_nxt   = 4'h0;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed bench for vga_fill_engine: hand-computed addresses, clipping, reject,
// zero-size, wait states, reset mid-fill and back-to-back commands.
module tb_vga_fill_engine;
  logic clk;
  logic rst;
  logic busy, done, err;

  vga_fill_engine_if bus ();

  vga_fill_engine #(.WIDTH(640), .HEIGHT(480), .BASE_ADDR(32'h0000_0000)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_adr [0:7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                         input logic [8:0] h, input logic [7:0] color);
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_w     = w;
    bus.cmd_h     = h;
    bus.cmd_color = color;
  endtask

  // Expect n pixels from exp_adr with 'dly' wait states each, then the done pulse and IDLE
  task automatic expect_fill(input int n, input int dly, input logic [7:0] color);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d <= dly; d++) begin
        check("adr", bus.m_adr, exp_adr[i]);
        check("stb", 32'(bus.m_stb), 32'd1);
        check("cyc_we", 32'({bus.m_cyc, bus.m_we}), 32'h3);
        check("dat", bus.m_dat, {24'h0, color});
        check("sel", 32'(bus.m_sel), 32'hF);
        check("ready_wr", 32'(bus.cmd_ready), 32'd0);
        check("busy_wr", 32'(busy), 32'd1);
        check("done_wr", 32'(done), 32'd0);
        bus.m_ack = (d == dly);
        step();
        bus.m_ack = 1'b0;
      end
    end
    check("done_pulse", 32'(done), 32'd1);
    check("err_done", 32'(err), 32'd0);
    check("bus_off", 32'({bus.m_cyc, bus.m_stb, bus.m_we}), 32'd0);
    check("busy_done", 32'(busy), 32'd1);
    check("ready_done", 32'(bus.cmd_ready), 32'd0);
    step();
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("ready_idle", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.m_ack     = 1'b0;
    set_cmd(10'd0, 9'd0, 10'd0, 9'd0, 8'h00);
    step();
    step();
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_bus", 32'({bus.m_cyc, bus.m_stb, bus.m_we}), 32'd0);
    check("rst_adr", bus.m_adr, 32'd0);
    check("rst_dat", bus.m_dat, 32'd0);
    check("rst_stat", 32'({busy, done, err}), 32'd0);
    rst = 1'b0;
    step();

    // 2x2 at origin, ack every cycle
    exp_adr[0] = 32'h0; exp_adr[1] = 32'h4; exp_adr[2] = 32'hA00; exp_adr[3] = 32'hA04;
    set_cmd(10'd0, 9'd0, 10'd2, 9'd2, 8'hE0);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    expect_fill(4, 0, 8'hE0);

    // Bottom-right corner, clipped to 2x1
    exp_adr[0] = 32'h12BFF8; exp_adr[1] = 32'h12BFFC;
    set_cmd(10'd638, 9'd479, 10'd10, 9'd5, 8'h1C);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    expect_fill(2, 0, 8'h1C);

    // Off-screen origin is rejected
    set_cmd(10'd640, 9'd0, 10'd4, 9'd4, 8'hFF);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("rej_err", 32'(err), 32'd1);
    check("rej_done", 32'(done), 32'd0);
    check("rej_cyc", 32'(bus.m_cyc), 32'd0);
    check("rej_busy", 32'(busy), 32'd1);
    check("rej_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    check("rej_err_clr", 32'(err), 32'd0);
    check("rej_idle", 32'({busy, bus.cmd_ready}), 32'b01);

    // Zero width on-screen completes without bus traffic
    set_cmd(10'd5, 9'd5, 10'd0, 9'd3, 8'h03);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    check("zero_cyc", 32'(bus.m_cyc), 32'd0);
    check("zero_busy", 32'(busy), 32'd1);
    step();
    check("zero_idle", 32'({busy, done, bus.cmd_ready}), 32'b001);

    // 1x1 with three wait states
    exp_adr[0] = 32'hA04;
    set_cmd(10'd1, 9'd1, 10'd1, 9'd1, 8'h5A);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    expect_fill(1, 3, 8'h5A);

    // Reset after second ack of a 3x1 fill, with a late ack around the reset
    set_cmd(10'd10, 9'd2, 10'd3, 9'd1, 8'h77);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("rs_adr0", bus.m_adr, 32'h1428);
    bus.m_ack = 1'b1;
    step();
    check("rs_adr1", bus.m_adr, 32'h142C);
    step();
    check("rs_adr2", bus.m_adr, 32'h1430);
    rst = 1'b1;
    step();
    check("rs_bus", 32'({bus.m_cyc, bus.m_stb, bus.m_we}), 32'd0);
    check("rs_adr", bus.m_adr, 32'd0);
    check("rs_sel", 32'(bus.m_sel), 32'd0);
    check("rs_stat", 32'({busy, done, err}), 32'd0);
    check("rs_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    step();
    check("late_ack_bus", 32'(bus.m_cyc), 32'd0);
    check("late_ack_stat", 32'({busy, done, err}), 32'd0);
    bus.m_ack = 1'b0;
    exp_adr[0] = 32'h0;
    set_cmd(10'd0, 9'd0, 10'd1, 9'd1, 8'h42);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    expect_fill(1, 0, 8'h42);

    // cmd_valid held high: second command only taken from IDLE after done
    exp_adr[0] = 32'hA00; exp_adr[1] = 32'hA04;
    set_cmd(10'd0, 9'd1, 10'd2, 9'd1, 8'h99);
    bus.cmd_valid = 1'b1;
    step();
    expect_fill(2, 1, 8'h99);
    step();
    expect_fill(2, 0, 8'h99);
    bus.cmd_valid = 1'b0;
    step();
    check("final_idle", 32'({bus.m_cyc, busy, bus.cmd_ready}), 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
